// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds the architectural widths, the nop and halt encodings, the queue entry
// record and a helper that word-aligns a fetch address.
package instruction_fetch_unit_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    // addi x0,x0,0 -- presented to decode whenever the queue is empty
    localparam logic [ILEN-1:0] NOP_WORD = 32'h0000_0013;
    // jal x0,0 -- a self loop; fetching it means the program is done
    localparam logic [ILEN-1:0] HALT_WORD_DEFAULT = 32'h0000_006F;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] insn;
    } fetch_entry_t;

    // Instructions are 4-byte aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// fetch_queue: circular FIFO of fetched {pc, instruction} entries.
// Ports:
//   clk_i, rst_ni  clock and synchronous active-low reset
//   flush_i        drop every entry (wins over push/pop in the same cycle)
//   push_i/data_i  enqueue at the tail; accepted when not full or popping
//   pop_i/data_o   dequeue the head; data_o always shows the head slot
//   full_o/empty_o occupancy flags
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module fetch_queue
    import instruction_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  fetch_entry_t data_i,
    output fetch_entry_t data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  head_q;
    logic [PW-1:0]  tail_q;
    logic [CW-1:0]  count_q;
    logic           do_push;
    logic           do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign data_o  = mem_q[head_q];

    assign do_pop  = pop_i & ~empty_o;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) tail_q <= tail_q + 1'b1;
            if (do_pop)  head_q <= head_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: count_q alone decides which slots are live.
    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_i && do_push) begin
            mem_q[tail_q] <= data_i;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC sequencing, halt detection and redirect handling
// in front of a small fetch queue that feeds decode.
// Ports:
//   clk, reset (sync, active-low)
//   inst_address -> combinational memory, instruction <- its read data
//   redirect_valid/redirect_pc  taken branch/jump from a later stage
//   if_valid/if_instruction/if_pc  queue head towards decode, id_ready accepts
//   halted      the halt word was fetched and fetch is stopped
//   misaligned  same-cycle flag for a redirect target with low bits set
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = 64'h0,
    parameter int              QUEUE_DEPTH = 2,
    parameter logic [ILEN-1:0] HALT_WORD   = HALT_WORD_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] inst_address,
    input  logic [ILEN-1:0] instruction,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            id_ready,
    output logic [ILEN-1:0] if_instruction,
    output logic [XLEN-1:0] if_pc,
    output logic            halted,
    output logic            misaligned
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            halted_q, halted_d;
    logic            fire;
    logic            deq;
    logic            q_full;
    logic            q_empty;
    fetch_entry_t    q_head;
    fetch_entry_t    q_push;

    // The address comes straight from the register, so id_ready never
    // reaches memory combinationally.
    assign inst_address = pc_q;
    assign halted       = halted_q;

    assign if_valid = ~q_empty;
    assign deq      = if_valid & id_ready;
    assign fire     = ~halted_q & ~redirect_valid & (~q_full | deq);

    assign q_push.pc   = pc_q;
    assign q_push.insn = instruction;

    assign if_instruction = q_empty ? NOP_WORD : q_head.insn;
    assign if_pc          = q_empty ? '0       : q_head.pc;

    // Reported in the redirect cycle itself; reset suppresses it.
    assign misaligned = reset & redirect_valid & (|redirect_pc[1:0]);

    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        if (redirect_valid) begin
            pc_d     = align_pc(redirect_pc);
            halted_d = 1'b0;
        end else if (fire) begin
            // The halt word is still queued, but the PC parks on it.
            if (instruction == HALT_WORD) begin
                halted_d = 1'b1;
            end else begin
                pc_d = pc_q + 64'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fetch_queue (
        .clk_i   (clk),
        .rst_ni  (reset),
        .flush_i (redirect_valid),
        .push_i  (fire),
        .pop_i   (deq),
        .data_i  (q_push),
        .data_o  (q_head),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HALT = 32'h0000_006F;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic [63:0] inst_address;
    logic [31:0] instruction;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] if_instruction;
    logic [63:0] if_pc;
    logic        halted;
    logic        misaligned;

    instruction_fetch_unit #(
        .RESET_PC    (64'h0),
        .QUEUE_DEPTH (2),
        .HALT_WORD   (HALT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .inst_address   (inst_address),
        .instruction    (instruction),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .id_ready       (id_ready),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .halted         (halted),
        .misaligned     (misaligned)
    );

    // ---------------- combinational instruction memory ----------------
    // Special words at 0x00, 0x40, 0x4C; everywhere else "addi x0,x0,<addr>".
    function automatic logic [31:0] mem_read(input logic [63:0] a);
        case (a)
            64'h00:  return 32'h00A0_0093;
            64'h40:  return 32'h06F0_0913;
            64'h4C:  return HALT;
            default: return {a[11:0], 20'h00013};
        endcase
    endfunction

    assign instruction = mem_read(inst_address);

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [63:0] pc,
                           input logic [31:0] ins, input logic [63:0] addr,
                           input logic h, input logic m);
        chk({tag, " if_valid"},       64'(if_valid),       64'(v));
        chk({tag, " if_pc"},          if_pc,               pc);
        chk({tag, " if_instruction"}, 64'(if_instruction), 64'(ins));
        chk({tag, " inst_address"},   inst_address,        addr);
        chk({tag, " halted"},         64'(halted),         64'(h));
        chk({tag, " misaligned"},     64'(misaligned),     64'(m));
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic rst, input logic rdy, input logic rv, input logic [63:0] rpc);
        reset          = rst;
        id_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [63:0] rpc;
        logic        valid;
        logic [63:0] pc;
        logic [31:0] ins;
        logic [63:0] addr;
        logic        halt;
        logic        mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic rdy, input logic rv,
                                input logic [63:0] rpc, input logic valid,
                                input logic [63:0] pc, input logic [31:0] ins,
                                input logic [63:0] addr, input logic halt, input logic mis);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.valid = valid; v.pc = pc; v.ins = ins; v.addr = addr;
        v.halt = halt; v.mis = mis;
        return v;
    endfunction

    initial begin
        //                 rst rdy rv  rpc     valid if_pc  if_instr      addr   halt mis
        vecs.push_back(mk(0, 0, 0, 64'h0,  0, 64'h0,  NOP,          64'h0,  0, 0)); // v0 in reset
        vecs.push_back(mk(1, 0, 0, 64'h0,  0, 64'h0,  NOP,          64'h0,  0, 0)); // v1 release
        vecs.push_back(mk(1, 0, 0, 64'h0,  1, 64'h0,  32'h00A00093, 64'h4,  0, 0)); // v2 first insn
        vecs.push_back(mk(1, 0, 0, 64'h0,  1, 64'h0,  32'h00A00093, 64'h8,  0, 0)); // v3 full
        vecs.push_back(mk(1, 0, 0, 64'h0,  1, 64'h0,  32'h00A00093, 64'h8,  0, 0));
        vecs.push_back(mk(1, 0, 0, 64'h0,  1, 64'h0,  32'h00A00093, 64'h8,  0, 0));
        vecs.push_back(mk(1, 0, 0, 64'h0,  1, 64'h0,  32'h00A00093, 64'h8,  0, 0)); // v6
        vecs.push_back(mk(1, 1, 0, 64'h0,  1, 64'h0,  32'h00A00093, 64'h8,  0, 0)); // v7 release
        vecs.push_back(mk(1, 1, 0, 64'h0,  1, 64'h4,  32'h00400013, 64'hC,  0, 0));
        vecs.push_back(mk(1, 1, 0, 64'h0,  1, 64'h8,  32'h00800013, 64'h10, 0, 0));
        vecs.push_back(mk(1, 0, 0, 64'h0,  1, 64'hC,  32'h00C00013, 64'h14, 0, 0)); // v10 full
        vecs.push_back(mk(1, 0, 1, 64'h40, 1, 64'hC,  32'h00C00013, 64'h14, 0, 0)); // v11 redirect
        vecs.push_back(mk(1, 1, 0, 64'h0,  0, 64'h0,  NOP,          64'h40, 0, 0)); // v12 flushed
        vecs.push_back(mk(1, 0, 0, 64'h0,  1, 64'h40, 32'h06F00913, 64'h44, 0, 0));
        vecs.push_back(mk(1, 1, 0, 64'h0,  1, 64'h40, 32'h06F00913, 64'h48, 0, 0));
        vecs.push_back(mk(1, 1, 0, 64'h0,  1, 64'h44, 32'h04400013, 64'h4C, 0, 0)); // v15 halt fetched
        vecs.push_back(mk(1, 1, 0, 64'h0,  1, 64'h48, 32'h04800013, 64'h4C, 1, 0));
        vecs.push_back(mk(1, 1, 0, 64'h0,  1, 64'h4C, HALT,         64'h4C, 1, 0));
        vecs.push_back(mk(1, 1, 0, 64'h0,  0, 64'h0,  NOP,          64'h4C, 1, 0));
        vecs.push_back(mk(1, 0, 0, 64'h0,  0, 64'h0,  NOP,          64'h4C, 1, 0));
        vecs.push_back(mk(1, 0, 1, 64'h0,  0, 64'h0,  NOP,          64'h4C, 1, 0)); // v20 redirect 0
        vecs.push_back(mk(1, 0, 0, 64'h0,  0, 64'h0,  NOP,          64'h0,  0, 0));
        vecs.push_back(mk(1, 1, 0, 64'h0,  1, 64'h0,  32'h00A00093, 64'h4,  0, 0));
        vecs.push_back(mk(1, 1, 1, 64'h42, 1, 64'h4,  32'h00400013, 64'h8,  0, 1)); // v23 misaligned
        vecs.push_back(mk(1, 1, 0, 64'h0,  0, 64'h0,  NOP,          64'h40, 0, 0));
        vecs.push_back(mk(1, 0, 0, 64'h0,  1, 64'h40, 32'h06F00913, 64'h44, 0, 0));
        vecs.push_back(mk(1, 0, 0, 64'h0,  1, 64'h40, 32'h06F00913, 64'h48, 0, 0)); // v26 full
        vecs.push_back(mk(0, 1, 1, 64'h82, 1, 64'h40, 32'h06F00913, 64'h48, 0, 0)); // v27 reset wins
        vecs.push_back(mk(1, 0, 0, 64'h0,  0, 64'h0,  NOP,          64'h0,  0, 0));
        vecs.push_back(mk(1, 1, 0, 64'h0,  1, 64'h0,  32'h00A00093, 64'h4,  0, 0));

        // ---------------- reset ----------------
        drive(0, 0, 0, 64'h0);
        repeat (3) @(posedge clk);
        #1;

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
            #1;
            chk_all($sformatf("v%0d", i), vecs[i].valid, vecs[i].pc, vecs[i].ins,
                    vecs[i].addr, vecs[i].halt, vecs[i].mis);
            next_cycle();
        end

        // ---------------- halt then reset mid-stream ----------------
        // State here: queue holds {4}, pc=8.
        drive(1, 1, 1, 64'h48);
        next_cycle();
        drive(1, 1, 0, 64'h0);
        #1;
        chk_all("hr0", 0, 64'h0, NOP, 64'h48, 0, 0);
        next_cycle(); // 0x48 queued
        #1;
        chk_all("hr1", 1, 64'h48, 32'h04800013, 64'h4C, 0, 0);
        next_cycle(); // 0x48 consumed, halt word queued
        drive(0, 0, 0, 64'h0);
        #1;
        chk_all("hr2", 1, 64'h4C, HALT, 64'h4C, 1, 0);
        next_cycle(); // reset edge
        drive(1, 0, 0, 64'h0);
        #1;
        chk_all("hr3", 0, 64'h0, NOP, 64'h0, 0, 0);

        // ---------------- pc wrap at 2^64 ----------------
        next_cycle(); // enqueue 0
        drive(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE);
        #1;
        chk("wr0 misaligned", 64'(misaligned), 64'h1);
        next_cycle();
        drive(1, 0, 0, 64'h0);
        #1;
        chk_all("wr1", 0, 64'h0, NOP, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
        next_cycle();
        #1;
        chk_all("wr2", 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFC00013, 64'h0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
